mdu: RTL

Parametrised multiply/divide unit that owns the HI/LO register pair for the `mips` core. It executes mult, multu, div, divu, mthi and mtlo. Multiply and divide results commit after a configurable number of cycles, and a `busy` flag lets the pipelined core stall on dependent instructions. The unit sits beside the ALU in the execute stage: it takes operands from the rs/rt forwarding muxes and returns HI/LO to the mfhi/mflo path.

---
 rtl/mdu.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mdu.sv
// Multiply/divide unit owning the HI/LO register pair. Results are computed at
// accept, held in pending registers, and committed after a fixed cycle count.
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     pend_hi;
    logic [WIDTH-1:0]     pend_lo;
    logic                 pend_we;

    logic                 accept;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;
    logic [2*WIDTH-1:0]   prod;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH-1:0]     b_div;
    logic [WIDTH-1:0]     q_mag;
    logic [WIDTH-1:0]     r_mag;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 div_zero;

    always_comb begin
        accept = start && (state == IDLE) && (op >= OP_MULT) && (op <= OP_MTLO);

        // Sign-extending to 2*WIDTH makes the truncated unsigned product equal the signed one.
        a_ext = (op == OP_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = (op == OP_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;

        // Divide on magnitudes so most-negative / -1 wraps cleanly to most-negative.
        a_neg    = (op == OP_DIV) && a[WIDTH-1];
        b_neg    = (op == OP_DIV) && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        div_zero = (b == '0);
        b_div    = div_zero ? WIDTH'(1) : b_mag;
        q_mag    = a_mag / b_div;
        r_mag    = a_mag % b_div;
        quo      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem      = a_neg ? -r_mag : r_mag;
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_we <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= prod[2*WIDTH-1:WIDTH];
                                pend_lo <= prod[WIDTH-1:0];
                                pend_we <= 1'b1;
                                count   <= CW'(MULT_CYCLES);
                                state   <= BUSY;
                                busy    <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi <= rem;
                                pend_lo <= quo;
                                pend_we <= !div_zero;
                                count   <= CW'(DIV_CYCLES);
                                state   <= BUSY;
                                busy    <= 1'b1;
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (count == CW'(1)) begin
                        if (pend_we) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
